// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - writeback source handshakes and CDB broadcast bundle
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  src0_valid;
    logic [ROB_WIDTH-1:0]  src0_rob_index;
    logic [DATA_WIDTH-1:0] src0_value;
    logic                  src0_ready;
    logic                  src1_valid;
    logic [ROB_WIDTH-1:0]  src1_rob_index;
    logic [DATA_WIDTH-1:0] src1_value;
    logic                  src1_ready;
    logic                  src2_valid;
    logic [ROB_WIDTH-1:0]  src2_rob_index;
    logic [DATA_WIDTH-1:0] src2_value;
    logic                  src2_ready;
    logic                  cdb_valid;
    logic [ROB_WIDTH-1:0]  cdb_rob_index;
    logic [DATA_WIDTH-1:0] cdb_value;
    logic [1:0]            cdb_src;

    modport slave (
        input  src0_valid, src0_rob_index, src0_value,
        input  src1_valid, src1_rob_index, src1_value,
        input  src2_valid, src2_rob_index, src2_value,
        output src0_ready, src1_ready, src2_ready,
        output cdb_valid, cdb_rob_index, cdb_value, cdb_src
    );

    modport master (
        output src0_valid, src0_rob_index, src0_value,
        output src1_valid, src1_rob_index, src1_value,
        output src2_valid, src2_rob_index, src2_value,
        input  src0_ready, src1_ready, src2_ready,
        input  cdb_valid, cdb_rob_index, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - three-source round-robin CDB arbiter with 2-entry FIFOs
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         clr_in,
    cdb_arbiter_if.slave bus
);
    localparam int NSRC = 3;

    logic [NSRC-1:0]       in_valid, in_ready, push, pop;
    logic [ROB_WIDTH-1:0]  in_rob [NSRC];
    logic [DATA_WIDTH-1:0] in_val [NSRC];

    logic [1:0]            cnt_q [NSRC];
    logic [1:0]            cnt_d [NSRC];
    logic [NSRC-1:0]       wp_q, rp_q;
    logic [ROB_WIDTH-1:0]  rob_mem_q [NSRC][2];
    logic [DATA_WIDTH-1:0] val_mem_q [NSRC][2];
    logic [1:0]            rr_last_q, rr_last_d;
    logic [1:0]            grant, cand;
    logic                  grant_vld;

    logic                  cdb_valid_q;
    logic [ROB_WIDTH-1:0]  cdb_rob_q;
    logic [DATA_WIDTH-1:0] cdb_val_q;
    logic [1:0]            cdb_src_q;

    assign in_valid  = {bus.src2_valid, bus.src1_valid, bus.src0_valid};
    assign in_rob[0] = bus.src0_rob_index;
    assign in_rob[1] = bus.src1_rob_index;
    assign in_rob[2] = bus.src2_rob_index;
    assign in_val[0] = bus.src0_value;
    assign in_val[1] = bus.src1_value;
    assign in_val[2] = bus.src2_value;

    assign bus.src0_ready    = in_ready[0];
    assign bus.src1_ready    = in_ready[1];
    assign bus.src2_ready    = in_ready[2];
    assign bus.cdb_valid     = cdb_valid_q;
    assign bus.cdb_rob_index = cdb_rob_q;
    assign bus.cdb_value     = cdb_val_q;
    assign bus.cdb_src       = cdb_src_q;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Ready looks only at registered counts so a pop this cycle never frees a slot early.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            in_ready[i] = rdy_in & ~clr_in & (cnt_q[i] < 2'(BUF_DEPTH));
        end
        push = in_valid & in_ready;
    end

    always_comb begin
        grant     = 2'd0;
        grant_vld = 1'b0;
        pop       = '0;
        cand      = rr_next(rr_last_q);
        for (int k = 0; k < NSRC; k++) begin
            if (!grant_vld && cnt_q[cand] != 2'd0) begin
                grant     = cand;
                grant_vld = 1'b1;
            end
            cand = rr_next(cand);
        end
        if (rdy_in && !clr_in && grant_vld) begin
            pop[grant] = 1'b1;
        end
        rr_last_d = (|pop) ? grant : rr_last_q;
        for (int i = 0; i < NSRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (pop[i] && !push[i]) begin
                cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i]        <= 2'd0;
                rob_mem_q[i][0] <= '0;
                rob_mem_q[i][1] <= '0;
                val_mem_q[i][0] <= '0;
                val_mem_q[i][1] <= '0;
            end
            wp_q        <= '0;
            rp_q        <= '0;
            rr_last_q   <= 2'd2;
            cdb_valid_q <= 1'b0;
            cdb_rob_q   <= '0;
            cdb_val_q   <= '0;
            cdb_src_q   <= 2'd0;
        end else if (clr_in) begin
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= 2'd0;
            end
            wp_q        <= '0;
            rp_q        <= '0;
            cdb_valid_q <= 1'b0;
        end else if (rdy_in) begin
            for (int i = 0; i < NSRC; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push[i]) begin
                    rob_mem_q[i][wp_q[i]] <= in_rob[i];
                    val_mem_q[i][wp_q[i]] <= in_val[i];
                    wp_q[i]               <= ~wp_q[i];
                end
                if (pop[i]) begin
                    rp_q[i] <= ~rp_q[i];
                end
            end
            rr_last_q   <= rr_last_d;
            cdb_valid_q <= grant_vld;
            if (grant_vld) begin
                cdb_rob_q <= rob_mem_q[grant][rp_q[grant]];
                cdb_val_q <= val_mem_q[grant][rp_q[grant]];
                cdb_src_q <= grant;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
    localparam int RW = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    src;
        logic [RW-1:0] rob;
        logic [DW-1:0] val;
    } ent_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b0;
    logic clr_in = 1'b0;
    logic [2:0]    v = '0;
    logic [RW-1:0] r [3];
    logic [DW-1:0] d [3];
    bit   [2:0]    acc;
    int total = 0;
    int bad = 0;

    ent_t mq [3][$];
    ent_t exp_q [$];
    int   rr = 2;
    bit   last_active = 1'b0;
    bit   last_clr = 1'b0;
    logic [38:0] hold_q = '0;

    cdb_arbiter_if #(.ROB_WIDTH(RW), .DATA_WIDTH(DW)) bus ();

    cdb_arbiter #(.ROB_WIDTH(RW), .DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .clr_in(clr_in),
        .bus(bus)
    );

    assign bus.src0_valid     = v[0];
    assign bus.src0_rob_index = r[0];
    assign bus.src0_value     = d[0];
    assign bus.src1_valid     = v[1];
    assign bus.src1_rob_index = r[1];
    assign bus.src1_value     = d[1];
    assign bus.src2_valid     = v[2];
    assign bus.src2_rob_index = r[2];
    assign bus.src2_value     = d[2];

    wire [2:0] rdy_o = {bus.src2_ready, bus.src1_ready, bus.src0_ready};

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: per-source queues, round-robin pick over sources holding results at the edge.
    always @(posedge clk_in or negedge rst_in) begin : model
        int   g;
        int   s;
        bit   [2:0] am;
        ent_t e;
        if (!rst_in) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            exp_q.delete();
            rr = 2;
            last_active = 1'b0;
            last_clr = 1'b0;
        end else begin
            last_active = rdy_in && !clr_in;
            last_clr = clr_in;
            if (clr_in) begin
                for (int i = 0; i < 3; i++) mq[i].delete();
            end else if (rdy_in) begin
                for (int i = 0; i < 3; i++) am[i] = v[i] && (mq[i].size() < 2);
                g = -1;
                for (int k = 1; k <= 3; k++) begin
                    s = (rr + k) % 3;
                    if (g < 0 && mq[s].size() > 0) g = s;
                end
                if (g >= 0) begin
                    exp_q.push_back(mq[g].pop_front());
                    rr = g;
                end
                for (int i = 0; i < 3; i++) begin
                    if (am[i]) begin
                        e.src = 2'(i);
                        e.rob = r[i];
                        e.val = d[i];
                        mq[i].push_back(e);
                    end
                end
            end
        end
    end

    always @(negedge clk_in) begin : monitor
        ent_t e;
        if (!rst_in) begin
            chk("reset_cdb_valid", 64'(bus.cdb_valid), 64'd0);
            hold_q = '0;
        end else begin
            if (last_clr) begin
                chk("flush_cdb_valid", 64'(bus.cdb_valid), 64'd0);
            end else if (last_active) begin
                chk("cdb_valid_vs_model", 64'(bus.cdb_valid), 64'(exp_q.size()));
                if (bus.cdb_valid && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("cdb_result", 64'({bus.cdb_src, bus.cdb_rob_index, bus.cdb_value}), 64'(e));
                end
            end else begin
                chk("stall_hold", 64'({bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index, bus.cdb_value}),
                    64'(hold_q));
            end
            hold_q = {bus.cdb_valid, bus.cdb_src, bus.cdb_rob_index, bus.cdb_value};
        end
    end

    task automatic offer(input int i, input logic [RW-1:0] rob, input logic [DW-1:0] val);
        if (!v[i]) begin
            v[i] = 1'b1;
            r[i] = rob;
            d[i] = val;
        end
    endtask

    task automatic tick(input bit rdy, input bit clr);
        rdy_in = rdy;
        clr_in = clr;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("src%0d_ready", i), 64'(rdy_o[i]), 64'(rdy && !clr && mq[i].size() < 2));
            acc[i] = v[i] & rdy_o[i];
        end
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) if (acc[i]) v[i] = 1'b0;
        if (clr) v = '0;
    endtask

    task automatic do_reset();
        #2 rst_in = 1'b0;
        v = '0;
        #1 chk("async_reset_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        @(negedge clk_in);
        #2 rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    initial begin : stim
        logic [RW-1:0] t2_rob [3];
        t2_rob[0] = 4'd1;
        t2_rob[1] = 4'd2;
        t2_rob[2] = 4'd4;
        for (int i = 0; i < 3; i++) begin
            r[i] = '0;
            d[i] = '0;
        end
        @(negedge clk_in);
        @(negedge clk_in);
        chk("reset_rob", 64'(bus.cdb_rob_index), 64'd0);
        chk("reset_value", 64'(bus.cdb_value), 64'd0);
        chk("reset_src", 64'(bus.cdb_src), 64'd0);
        #2 rst_in = 1'b1;
        @(negedge clk_in);

        // single push, one-cycle latency
        offer(0, 4'd3, 32'h11);
        tick(1, 0);
        tick(1, 0);
        chk("t1_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t1_rob", 64'(bus.cdb_rob_index), 64'd3);
        chk("t1_value", 64'(bus.cdb_value), 64'h11);
        chk("t1_src", 64'(bus.cdb_src), 64'd0);
        tick(1, 0);
        chk("t1_idle", 64'(bus.cdb_valid), 64'd0);

        // simultaneous push from fresh reset: src 0,1,2 in order
        do_reset();
        offer(0, 4'd1, $urandom);
        offer(1, 4'd2, $urandom);
        offer(2, 4'd4, $urandom);
        tick(1, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1, 0);
            chk($sformatf("t2_rob%0d", k), 64'(bus.cdb_rob_index), 64'(t2_rob[k]));
            chk($sformatf("t2_src%0d", k), 64'(bus.cdb_src), 64'(k));
        end
        tick(1, 0);
        chk("t2_idle", 64'(bus.cdb_valid), 64'd0);

        // backpressure with two continuous sources
        for (int k = 0; k < 6; k++) begin
            offer(0, 4'($urandom), $urandom);
            offer(1, 4'($urandom), $urandom);
            tick(1, 0);
        end
        repeat (10) tick(1, 0);

        // flush with every source busy
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) offer(i, 4'($urandom), $urandom);
            tick(1, 0);
        end
        offer(1, 4'($urandom), $urandom);
        tick(1, 1);
        chk("t4_post_flush_valid", 64'(bus.cdb_valid), 64'd0);
        repeat (4) tick(1, 0);

        // stall while a result sits on the CDB
        offer(0, 4'd5, $urandom);
        tick(1, 0);
        tick(1, 0);
        chk("t5_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t5_rob", 64'(bus.cdb_rob_index), 64'd5);
        offer(2, 4'($urandom), $urandom);
        repeat (4) tick(0, 0);
        chk("t5_hold_rob", 64'(bus.cdb_rob_index), 64'd5);
        repeat (4) tick(1, 0);

        // async reset with results pending
        for (int i = 0; i < 3; i++) offer(i, 4'($urandom), $urandom);
        tick(1, 0);
        tick(1, 0);
        do_reset();
        for (int i = 0; i < 3; i++) offer(i, 4'($urandom), $urandom);
        tick(1, 0);
        tick(1, 0);
        chk("t6_first_valid", 64'(bus.cdb_valid), 64'd1);
        chk("t6_first_src", 64'(bus.cdb_src), 64'd0);
        repeat (4) tick(1, 0);

        // random traffic with stalls and occasional flushes
        repeat (400) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 99) < 55) offer(i, 4'($urandom), $urandom);
            end
            tick($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
        end
        repeat (12) tick(1, 0);
        chk("final_pending", 64'(exp_q.size() + mq[0].size() + mq[1].size() + mq[2].size()), 64'd0);
        chk("final_cdb_idle", 64'(bus.cdb_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
